victim_cache_nway: RTL and testbench



---
 rtl/victim_cache_nway.sv | 257 +++++++++++++++++++++++++
 tb/tb_victim_cache_nway.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/victim_cache_nway.sv
// victim_cache_nway: fully associative, true-LRU victim cache kept exclusive with L1 (a probe hit hands the line back and frees it).
// Latency: probe result one cycle after acceptance; an insert commits one cycle after acceptance, or on the write-back handshake if a dirty LRU line must leave.
// Backpressure: ready outputs are high only in IDLE; a stalled write-back or a running flush blocks every new request.
module victim_cache_nway #(
  parameter int ENTRIES  = 4,
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4,
  parameter int CNT_W    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     lookup_valid_i,
  output logic                     lookup_ready_o,
  input  logic [ADDR_W-1:0]        lookup_addr_i,
  output logic                     lookup_done_o,
  output logic                     lookup_hit_o,
  output logic                     lookup_dirty_o,
  output logic [LINE_W-1:0]        lookup_data_o,
  input  logic                     evict_valid_i,
  output logic                     evict_ready_o,
  input  logic [ADDR_W-1:0]        evict_addr_i,
  input  logic [LINE_W-1:0]        evict_data_i,
  input  logic                     evict_dirty_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [ADDR_W-1:0]        wb_addr_o,
  output logic [LINE_W-1:0]        wb_data_o,
  input  logic                     flush_i,
  output logic                     flush_busy_o,
  output logic [CNT_W-1:0]         no_acc_o,
  output logic [CNT_W-1:0]         no_hit_o,
  output logic [CNT_W-1:0]         no_miss_o,
  output logic [$clog2(ENTRIES):0] occupancy_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = IDX_W + 1;
  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  // Request captured at acceptance; a probe only uses the tag.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
    logic              dirty;
  } req_t;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, INSERT, WB, FLUSH_SCAN, FLUSH_WB
  } state_t;

  state_t state, state_nxt;
  req_t   req;

  logic [ENTRIES-1:0] valid, dirty, valid_nxt, dirty_nxt;
  logic [TAG_W-1:0]   tag_mem  [ENTRIES];
  logic [LINE_W-1:0]  data_mem [ENTRIES];
  logic [IDX_W-1:0]   age      [ENTRIES];

  logic [IDX_W-1:0] slot, scan_idx;
  logic [IDX_W-1:0] match_idx, free_idx, lru_idx, ins_idx, commit_idx;
  logic             match_any, free_any;
  logic             ins_wb, commit, commit_dirty, probe_hit;
  logic             scan_dirty, scan_last, flush_clear;
  logic             unused_offset;

  assign unused_offset = ^{lookup_addr_i[OFFSET_W-1:0], evict_addr_i[OFFSET_W-1:0]};

  function automatic logic [OCC_W-1:0] popcount(input logic [ENTRIES-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int i = 0; i < ENTRIES; i++) n = n + OCC_W'(v[i]);
    return n;
  endfunction

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; flush beats lookup beats evict in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (flush_i)             state_nxt = FLUSH_SCAN;
        else if (lookup_valid_i) state_nxt = LOOKUP;
        else if (evict_valid_i)  state_nxt = INSERT;
      end
      LOOKUP:     state_nxt = IDLE;
      INSERT:     state_nxt = ins_wb ? WB : IDLE;
      WB:         if (wb_ready_i) state_nxt = IDLE;
      FLUSH_SCAN: begin
        if (scan_dirty)     state_nxt = FLUSH_WB;
        else if (scan_last) state_nxt = IDLE;
      end
      FLUSH_WB:   if (wb_ready_i) state_nxt = scan_last ? IDLE : FLUSH_SCAN;
      default:    state_nxt = IDLE;
    endcase
  end

  // FSM outputs; readies are forced low while reset is held.
  always_comb begin
    lookup_ready_o = (state == IDLE) && !flush_i && !rst_i;
    evict_ready_o  = (state == IDLE) && !flush_i && !rst_i && !lookup_valid_i;
    wb_valid_o     = (state == WB) || (state == FLUSH_WB);
    flush_busy_o   = (state == FLUSH_SCAN) || (state == FLUSH_WB);
  end

  // Tag match, lowest free slot and LRU slot, all against the captured request.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    lru_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && (tag_mem[i] == req.tag)) begin
        match_any = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (age[i] == LAST_IDX) lru_idx = IDX_W'(i);
    end
  end

  // Insert target, commit strobe and flush bookkeeping.
  always_comb begin
    ins_idx      = match_any ? match_idx : (free_any ? free_idx : lru_idx);
    ins_wb       = !match_any && !free_any && dirty[lru_idx];
    commit       = ((state == INSERT) && !ins_wb) || ((state == WB) && wb_ready_i);
    commit_idx   = (state == WB) ? slot : ins_idx;
    commit_dirty = ((state == INSERT) && match_any) ? (dirty[match_idx] | req.dirty) : req.dirty;
    probe_hit    = (state == LOOKUP) && match_any;
    scan_dirty   = valid[scan_idx] && dirty[scan_idx];
    scan_last    = (scan_idx == LAST_IDX);
    flush_clear  = ((state == FLUSH_SCAN) && !scan_dirty) || ((state == FLUSH_WB) && wb_ready_i);
  end

  // Next valid/dirty vectors; the three update sources are state-exclusive.
  always_comb begin
    valid_nxt = valid;
    dirty_nxt = dirty;
    if (commit) begin
      valid_nxt[commit_idx] = 1'b1;
      dirty_nxt[commit_idx] = commit_dirty;
    end
    if (probe_hit) begin
      valid_nxt[match_idx] = 1'b0;
      dirty_nxt[match_idx] = 1'b0;
    end
    if (flush_clear) begin
      valid_nxt[scan_idx] = 1'b0;
      dirty_nxt[scan_idx] = 1'b0;
    end
  end

  // Capture the accepted request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req <= '0;
    end else if ((state == IDLE) && !flush_i) begin
      if (lookup_valid_i) begin
        req.tag   <= lookup_addr_i[ADDR_W-1:OFFSET_W];
        req.data  <= '0;
        req.dirty <= 1'b0;
      end else if (evict_valid_i) begin
        req.tag   <= evict_addr_i[ADDR_W-1:OFFSET_W];
        req.data  <= evict_data_i;
        req.dirty <= evict_dirty_i;
      end
    end
  end

  // Line storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      tag_mem[commit_idx]  <= req.tag;
      data_mem[commit_idx] <= req.data;
    end
  end

  // Valid/dirty/age state and occupancy; ages stay a permutation with 0 = MRU.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid       <= '0;
      dirty       <= '0;
      occupancy_o <= '0;
      for (int i = 0; i < ENTRIES; i++) age[i] <= IDX_W'(i);
    end else begin
      valid       <= valid_nxt;
      dirty       <= dirty_nxt;
      occupancy_o <= popcount(valid_nxt);
      if (commit) begin
        for (int j = 0; j < ENTRIES; j++) begin
          if (IDX_W'(j) == commit_idx)      age[j] <= '0;
          else if (age[j] < age[commit_idx]) age[j] <= age[j] + IDX_W'(1);
        end
      end
    end
  end

  // Pending-insert slot and flush scan pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot     <= '0;
      scan_idx <= '0;
    end else begin
      if (state == INSERT) slot <= ins_idx;
      if ((state == IDLE) && flush_i)     scan_idx <= '0;
      else if (flush_clear && !scan_last) scan_idx <= scan_idx + IDX_W'(1);
    end
  end

  // Write-back line, loaded when the FSM heads into WB or FLUSH_WB and then held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_addr_o <= '0;
      wb_data_o <= '0;
    end else if ((state == INSERT) && ins_wb) begin
      wb_addr_o <= {tag_mem[lru_idx], {OFFSET_W{1'b0}}};
      wb_data_o <= data_mem[lru_idx];
    end else if ((state == FLUSH_SCAN) && scan_dirty) begin
      wb_addr_o <= {tag_mem[scan_idx], {OFFSET_W{1'b0}}};
      wb_data_o <= data_mem[scan_idx];
    end
  end

  // Probe result registers and statistics counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lookup_done_o  <= 1'b0;
      lookup_hit_o   <= 1'b0;
      lookup_dirty_o <= 1'b0;
      lookup_data_o  <= '0;
      no_acc_o       <= '0;
      no_hit_o       <= '0;
      no_miss_o      <= '0;
    end else begin
      lookup_done_o <= (state == LOOKUP);
      if (state == LOOKUP) begin
        lookup_hit_o   <= match_any;
        lookup_dirty_o <= match_any && dirty[match_idx];
        lookup_data_o  <= match_any ? data_mem[match_idx] : '0;
        no_acc_o       <= no_acc_o + CNT_W'(1);
        if (match_any) no_hit_o  <= no_hit_o + CNT_W'(1);
        else           no_miss_o <= no_miss_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_victim_cache_nway.sv
// Directed bench for victim_cache_nway (ENTRIES=4, 128-bit lines).
// Expected values are hand-derived from the LRU/exclusive-cache rules.
// Drives and samples on the falling clock edge.
module tb_victim_cache_nway;

  logic         clk;
  logic         rst;
  logic         lookup_valid, lookup_ready, lookup_done, lookup_hit, lookup_dirty;
  logic [31:0]  lookup_addr;
  logic [127:0] lookup_data;
  logic         evict_valid, evict_ready, evict_dirty;
  logic [31:0]  evict_addr;
  logic [127:0] evict_data;
  logic         wb_valid, wb_ready;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic         flush, flush_busy;
  logic [31:0]  no_acc, no_hit, no_miss;
  logic [2:0]   occupancy;

  int n_assert = 0;
  int n_fail   = 0;

  victim_cache_nway #(
    .ENTRIES(4), .ADDR_W(32), .LINE_W(128), .OFFSET_W(4), .CNT_W(32)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready),
    .lookup_addr_i(lookup_addr), .lookup_done_o(lookup_done),
    .lookup_hit_o(lookup_hit), .lookup_dirty_o(lookup_dirty),
    .lookup_data_o(lookup_data),
    .evict_valid_i(evict_valid), .evict_ready_o(evict_ready),
    .evict_addr_i(evict_addr), .evict_data_i(evict_data), .evict_dirty_i(evict_dirty),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_addr_o(wb_addr), .wb_data_o(wb_data),
    .flush_i(flush), .flush_busy_o(flush_busy),
    .no_acc_o(no_acc), .no_hit_o(no_hit), .no_miss_o(no_miss),
    .occupancy_o(occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int n);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(n);
    return {4{w}};
  endfunction

  // Called at a falling edge; returns at the falling edge inside the done cycle.
  task automatic do_lookup(input logic [31:0] a, output logic hit, output logic dty,
                           output logic [127:0] dat);
    lookup_valid = 1'b1;
    lookup_addr  = a;
    #1;
    for (int k = 0; k < 100; k++) begin
      if (lookup_ready) break;
      @(negedge clk); #1;
    end
    chk_b("lk_accept", lookup_ready, 1'b1);
    @(negedge clk);
    lookup_valid = 1'b0;
    chk_b("lk_not_early", lookup_done, 1'b0);
    @(negedge clk);
    chk_b("lk_done", lookup_done, 1'b1);
    hit = lookup_hit;
    dty = lookup_dirty;
    dat = lookup_data;
  endtask

  // Called at a falling edge; returns at the falling edge right after acceptance.
  task automatic do_insert(input logic [31:0] a, input logic [127:0] d, input logic dty);
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_data  = d;
    evict_dirty = dty;
    #1;
    for (int k = 0; k < 100; k++) begin
      if (evict_ready) break;
      @(negedge clk); #1;
    end
    chk_b("ev_accept", evict_ready, 1'b1);
    @(negedge clk);
    evict_valid = 1'b0;
  endtask

  initial begin
    logic         h, dy;
    logic [127:0] dt;
    logic [127:0] d_a5;
    logic [31:0]  wa [4];
    logic [127:0] wd [4];
    int           nwb;

    d_a5 = {16{8'hA5}};
    rst = 1'b1; lookup_valid = 1'b0; lookup_addr = '0;
    evict_valid = 1'b0; evict_addr = '0; evict_data = '0; evict_dirty = 1'b0;
    wb_ready = 1'b0; flush = 1'b0;

    // Reset values
    #7;
    chk_b("rst_lookup_ready", lookup_ready, 1'b0);
    chk_b("rst_evict_ready", evict_ready, 1'b0);
    chk_b("rst_done", lookup_done, 1'b0);
    chk_b("rst_hit", lookup_hit, 1'b0);
    chk_w("rst_data", lookup_data, 128'd0);
    chk_b("rst_wb_valid", wb_valid, 1'b0);
    chk_b("rst_flush_busy", flush_busy, 1'b0);
    chk_w("rst_counters", 128'({no_acc, no_hit, no_miss}), 128'd0);
    chk_w("rst_occ", 128'(occupancy), 128'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk_b("idle_lookup_ready", lookup_ready, 1'b1);

    // Probe of an empty cache misses
    do_lookup(32'h1000, h, dy, dt);
    chk_b("p1_hit", h, 1'b0);
    chk_w("p1_data", dt, 128'd0);
    chk_w("p1_acc", 128'(no_acc), 128'd1);
    chk_w("p1_miss", 128'(no_miss), 128'd1);
    chk_w("p1_occ", 128'(occupancy), 128'd0);
    @(negedge clk);
    chk_b("p1_done_one_cycle", lookup_done, 1'b0);

    // Insert then probe the same line at another offset
    do_insert(32'h1000, d_a5, 1'b0);
    @(negedge clk);
    chk_w("p2_occ_one", 128'(occupancy), 128'd1);
    do_lookup(32'h1008, h, dy, dt);
    chk_b("p2_hit", h, 1'b1);
    chk_w("p2_data", dt, d_a5);
    chk_b("p2_dirty", dy, 1'b0);
    chk_w("p2_occ_zero", 128'(occupancy), 128'd0);
    chk_w("p2_no_hit", 128'(no_hit), 128'd1);

    // Lookup and evict together: lookup first, evict afterwards
    lookup_valid = 1'b1; lookup_addr = 32'hA00;
    evict_valid = 1'b1; evict_addr = 32'hA00; evict_data = pat(10); evict_dirty = 1'b0;
    #1;
    chk_b("sim_lookup_ready", lookup_ready, 1'b1);
    chk_b("sim_evict_ready", evict_ready, 1'b0);
    @(negedge clk);
    lookup_valid = 1'b0;
    @(negedge clk);
    chk_b("sim_done", lookup_done, 1'b1);
    chk_b("sim_hit", lookup_hit, 1'b0);
    chk_b("sim_evict_ready_later", evict_ready, 1'b1);
    @(negedge clk);
    evict_valid = 1'b0;
    do_lookup(32'hA00, h, dy, dt);
    chk_b("sim_probe_hit", h, 1'b1);
    chk_w("sim_probe_data", dt, pat(10));
    chk_w("sim_acc", 128'(no_acc), 128'd4);

    // Fill four entries, then force a dirty LRU write-back held off for 3 cycles
    do_insert(32'h000, pat(0), 1'b1);
    do_insert(32'h010, pat(1), 1'b0);
    do_insert(32'h020, pat(2), 1'b0);
    do_insert(32'h030, pat(3), 1'b0);
    do_insert(32'h040, pat(4), 1'b0);
    @(negedge clk);
    chk_b("wb_valid_rise", wb_valid, 1'b1);
    chk_w("wb_addr", 128'(wb_addr), 128'h0);
    chk_w("wb_data", wb_data, pat(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_b("wb_hold_valid", wb_valid, 1'b1);
      chk_w("wb_hold_addr", 128'(wb_addr), 128'h0);
      chk_w("wb_hold_data", wb_data, pat(0));
      chk_b("wb_hold_evict_ready", evict_ready, 1'b0);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk_b("wb_done", wb_valid, 1'b0);
    chk_w("wb_occ", 128'(occupancy), 128'd4);
    do_lookup(32'h040, h, dy, dt);
    chk_b("wb_new_hit", h, 1'b1);
    chk_w("wb_new_data", dt, pat(4));
    do_lookup(32'h000, h, dy, dt);
    chk_b("wb_old_miss", h, 1'b0);
    chk_w("wb_occ_after", 128'(occupancy), 128'd3);
    chk_w("wb_acc", 128'(no_acc), 128'd6);
    chk_w("wb_miss", 128'(no_miss), 128'd3);

    // Same line inserted twice: one new entry, dirty bits merge
    do_insert(32'h050, pat(5), 1'b0);
    @(negedge clk);
    chk_w("dup_occ_first", 128'(occupancy), 128'd4);
    do_insert(32'h050, pat(6), 1'b1);
    @(negedge clk);
    chk_w("dup_occ_second", 128'(occupancy), 128'd4);
    do_lookup(32'h050, h, dy, dt);
    chk_b("dup_hit", h, 1'b1);
    chk_b("dup_dirty", dy, 1'b1);
    chk_w("dup_data", dt, pat(6));

    // Leave two dirty + one clean entry, then flush
    do_lookup(32'h010, h, dy, dt);
    chk_w("pre_flush_data1", dt, pat(1));
    do_lookup(32'h020, h, dy, dt);
    chk_w("pre_flush_data2", dt, pat(2));
    do_insert(32'h060, pat(7), 1'b1);
    do_insert(32'h070, pat(8), 1'b1);
    @(negedge clk);
    chk_w("pre_flush_occ", 128'(occupancy), 128'd3);
    wb_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk_b("flush_busy_rise", flush_busy, 1'b1);
    chk_b("flush_blocks_lookup", lookup_ready, 1'b0);
    nwb = 0;
    for (int k = 0; k < 40; k++) begin
      if (!flush_busy) break;
      if (wb_valid) begin
        if (nwb < 4) begin
          wa[nwb] = wb_addr;
          wd[nwb] = wb_data;
        end
        nwb++;
      end
      @(negedge clk);
    end
    wb_ready = 1'b0;
    chk_b("flush_busy_fall", flush_busy, 1'b0);
    chk_w("flush_wb_count", 128'(nwb), 128'd2);
    chk_w("flush_wb0_addr", 128'(wa[0]), 128'h60);
    chk_w("flush_wb0_data", wd[0], pat(7));
    chk_w("flush_wb1_addr", 128'(wa[1]), 128'h70);
    chk_w("flush_wb1_data", wd[1], pat(8));
    chk_w("flush_occ", 128'(occupancy), 128'd0);
    chk_w("flush_counters", 128'({no_acc, no_hit, no_miss}), {32'd0, 32'd9, 32'd6, 32'd3});

    // Reset in the middle of a write-back
    do_insert(32'h100, pat(0), 1'b1);
    do_insert(32'h110, pat(1), 1'b1);
    do_insert(32'h120, pat(2), 1'b1);
    do_insert(32'h130, pat(3), 1'b1);
    do_insert(32'h140, pat(4), 1'b1);
    @(negedge clk);
    chk_b("arst_pre_wb_valid", wb_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_b("arst_wb_valid", wb_valid, 1'b0);
    chk_b("arst_lookup_ready", lookup_ready, 1'b0);
    chk_b("arst_evict_ready", evict_ready, 1'b0);
    chk_b("arst_flush_busy", flush_busy, 1'b0);
    chk_w("arst_counters", 128'({no_acc, no_hit, no_miss}), 128'd0);
    chk_w("arst_occ", 128'(occupancy), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_w("arst_occ_after", 128'(occupancy), 128'd0);
    do_lookup(32'h140, h, dy, dt);
    chk_b("arst_insert_lost", h, 1'b0);
    chk_w("arst_acc", 128'(no_acc), 128'd1);
    chk_w("arst_miss", 128'(no_miss), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
